// File: rtl/add_rs.sv
// add_rs: add/sub reservation station; buffers issued ops until both operands are present,
// captures operands from the CDB, and dispatches the oldest ready op to the add unit.
// Optional feature macro: ADD_RS_FLUSH_EN adds a flush port that discards all entries.
module add_rs #(
    parameter int RS_NUM = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_aluc,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [TAG_W-1:0]  issue_dest,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
`ifdef ADD_RS_FLUSH_EN
    input  logic              flush,
`endif
    output logic              fu_valid,
    input  logic              fu_ready,
    output logic [DATA_W-1:0] fu_add1,
    output logic [DATA_W-1:0] fu_add2,
    output logic              fu_aluc,
    output logic [TAG_W-1:0]  fu_dest,
    output logic [3:0]        busy_cnt
);
    localparam int IW = (RS_NUM > 1) ? $clog2(RS_NUM) : 1;

    logic              busy_q [RS_NUM];
    logic              busy_d [RS_NUM];
    logic              aluc_q [RS_NUM];
    logic              aluc_d [RS_NUM];
    logic [DATA_W-1:0] vj_q   [RS_NUM];
    logic [DATA_W-1:0] vj_d   [RS_NUM];
    logic [DATA_W-1:0] vk_q   [RS_NUM];
    logic [DATA_W-1:0] vk_d   [RS_NUM];
    logic [TAG_W-1:0]  qj_q   [RS_NUM];
    logic [TAG_W-1:0]  qj_d   [RS_NUM];
    logic [TAG_W-1:0]  qk_q   [RS_NUM];
    logic [TAG_W-1:0]  qk_d   [RS_NUM];
    logic [TAG_W-1:0]  dest_q [RS_NUM];
    logic [TAG_W-1:0]  dest_d [RS_NUM];
    logic [IW-1:0]     age_q  [RS_NUM];
    logic [IW-1:0]     age_d  [RS_NUM];
    logic [3:0]        busy_cnt_q;
    logic [3:0]        busy_cnt_d;

    logic          sel_valid;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] sel_age;
    logic [IW-1:0] free_idx;
    logic          issue_fire;
    logic          disp_fire;
    logic [3:0]    stay_cnt;
    logic          hit_j;
    logic          hit_k;

    assign issue_ready = busy_cnt_q < 4'(RS_NUM);
    assign busy_cnt    = busy_cnt_q;
    assign issue_fire  = issue_valid && issue_ready;
    assign disp_fire   = sel_valid && fu_ready;
    assign stay_cnt    = busy_cnt_q - {3'b0, disp_fire};
    assign hit_j       = cdb_valid && issue_qj != '0 && issue_qj == cdb_tag;
    assign hit_k       = cdb_valid && issue_qk != '0 && issue_qk == cdb_tag;

    // Oldest entry whose operands are both present in registered state wins dispatch.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 && (!sel_valid || age_q[i] < sel_age)) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = age_q[i];
            end
        end
    end

    // Lowest-index free entry, judged from registered busy bits only.
    always_comb begin
        free_idx = '0;
        for (int i = RS_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IW'(i);
        end
    end

    // Add-unit interface: selected entry, forced to zero when nothing is ready.
    always_comb begin
        fu_valid = sel_valid;
        fu_add1  = sel_valid ? vj_q[sel_idx]   : '0;
        fu_add2  = sel_valid ? vk_q[sel_idx]   : '0;
        fu_aluc  = sel_valid ? aluc_q[sel_idx] : 1'b0;
        fu_dest  = sel_valid ? dest_q[sel_idx] : '0;
    end

    // Next entry state: wakeup, age compaction on dispatch, dispatch free, issue write.
    always_comb begin
        busy_d     = busy_q;
        aluc_d     = aluc_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        dest_d     = dest_q;
        age_d      = age_q;
        busy_cnt_d = busy_cnt_q + {3'b0, issue_fire} - {3'b0, disp_fire};
        for (int i = 0; i < RS_NUM; i++) begin
            if (busy_q[i] && cdb_valid && qj_q[i] != '0 && qj_q[i] == cdb_tag) begin
                vj_d[i] = cdb_data;
                qj_d[i] = '0;
            end
            if (busy_q[i] && cdb_valid && qk_q[i] != '0 && qk_q[i] == cdb_tag) begin
                vk_d[i] = cdb_data;
                qk_d[i] = '0;
            end
            if (disp_fire && busy_q[i] && age_q[i] > sel_age) age_d[i] = age_q[i] - 1'b1;
        end
        if (disp_fire) busy_d[sel_idx] = 1'b0;
        if (issue_fire) begin
            busy_d[free_idx] = 1'b1;
            aluc_d[free_idx] = issue_aluc;
            vj_d[free_idx]   = hit_j ? cdb_data : issue_vj;
            qj_d[free_idx]   = hit_j ? '0 : issue_qj;
            vk_d[free_idx]   = hit_k ? cdb_data : issue_vk;
            qk_d[free_idx]   = hit_k ? '0 : issue_qk;
            dest_d[free_idx] = issue_dest;
            age_d[free_idx]  = IW'(stay_cnt);
        end
`ifdef ADD_RS_FLUSH_EN
        if (flush) begin
            for (int i = 0; i < RS_NUM; i++) busy_d[i] = 1'b0;
            busy_cnt_d = '0;
        end
`endif
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_NUM; i++) begin
                busy_q[i] <= 1'b0;
                aluc_q[i] <= 1'b0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
                age_q[i]  <= '0;
            end
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            aluc_q     <= aluc_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            dest_q     <= dest_d;
            age_q      <= age_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end
endmodule

// File: tb/tb_add_rs.sv
// tb_add_rs: scoreboard bench for add_rs; expected dispatches are queued as stimulus is driven.
module tb_add_rs;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, issue_aluc;
    logic [31:0] issue_vj, issue_vk, cdb_data, fu_add1, fu_add2;
    logic [3:0]  issue_qj, issue_qk, issue_dest, cdb_tag, fu_dest, busy_cnt;
    logic        cdb_valid, fu_valid, fu_ready, fu_aluc;
`ifdef ADD_RS_FLUSH_EN
    logic        flush;
`endif
    logic [68:0] sb[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    add_rs dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_aluc(issue_aluc),
        .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
        .issue_dest(issue_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
`ifdef ADD_RS_FLUSH_EN
        .flush(flush),
`endif
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_add1(fu_add1), .fu_add2(fu_add2),
        .fu_aluc(fu_aluc), .fu_dest(fu_dest), .busy_cnt(busy_cnt)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [68:0] op(input bit a, input logic [3:0] d, input logic [31:0] x, input logic [31:0] y);
        return {a, d, x, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input bit a, input logic [31:0] vj, input logic [3:0] qj,
                             input logic [31:0] vk, input logic [3:0] qk, input logic [3:0] d);
        issue_valid = 1'b1;
        issue_aluc  = a;
        issue_vj    = vj;
        issue_qj    = qj;
        issue_vk    = vk;
        issue_qk    = qk;
        issue_dest  = d;
    endtask

    task automatic issue(input bit a, input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk, input logic [3:0] d);
        set_issue(a, vj, qj, vk, qk, d);
        step();
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        step();
        cdb_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && fu_valid && fu_ready) begin
            if (sb.size() == 0) check("unexpected_dispatch", 96'(sb.size()), 96'd1);
            else check("dispatch", {fu_aluc, fu_dest, fu_add1, fu_add2}, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; issue_valid = 0; issue_aluc = 0; issue_vj = 0; issue_qj = 0;
        issue_vk = 0; issue_qk = 0; issue_dest = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        fu_ready = 1'b1;
`ifdef ADD_RS_FLUSH_EN
        flush = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        check("rst_ready", issue_ready, 1);
        check("rst_fu_valid", fu_valid, 0);
        check("rst_busy", busy_cnt, 0);
        check("rst_fu_bus", {fu_aluc, fu_dest, fu_add1, fu_add2}, 0);

        sb.push_back(op(0, 1, 5, 7));
        issue(0, 5, 0, 7, 0, 1);
        check("ready_valid", fu_valid, 1);
        check("ready_busy1", busy_cnt, 1);
        step();
        check("ready_busy0", busy_cnt, 0);
        check("ready_idle", fu_valid, 0);

        issue(1, 0, 3, 2, 0, 2);
        check("wake_wait", fu_valid, 0);
        step();
        check("wake_wait2", fu_valid, 0);
        sb.push_back(op(1, 2, 10, 2));
        cdb_valid = 1; cdb_tag = 3; cdb_data = 10;
        #1 check("wake_early", fu_valid, 0);
        step();
        cdb_valid = 0;
        check("wake_lat", fu_valid, 1);
        step();
        check("wake_busy0", busy_cnt, 0);

        sb.push_back(op(0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        set_issue(0, 0, 5, 0, 5, 3);
        cdb_valid = 1; cdb_tag = 5; cdb_data = 32'hFFFF_FFFF;
        step();
        issue_valid = 0; cdb_valid = 0;
        check("bypass_ready", fu_valid, 1);
        step();

        fu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(op(i[0], 4'(4 + i), 32'(100 + i), 32'(200 + i)));
            issue(i[0], 32'(100 + i), 0, 32'(200 + i), 0, 4'(4 + i));
        end
        check("full_ready", issue_ready, 0);
        check("full_busy", busy_cnt, 3);
        issue(0, 9, 0, 9, 0, 7);
        check("full_ignored", busy_cnt, 3);
        check("full_hold", fu_dest, 4);
        fu_ready = 1;
        step();
        check("drain_busy2", busy_cnt, 2);
        step(); step();
        check("drain_busy0", busy_cnt, 0);

        issue(0, 0, 2, 1, 0, 8);
        sb.push_back(op(0, 9, 3, 4));
        issue(0, 3, 0, 4, 0, 9);
        check("oldest_b_sel", fu_dest, 9);
        sb.push_back(op(0, 8, 20, 1));
        cdb(2, 20);
        check("oldest_a_sel", fu_dest, 8);
        step();
        check("oldest_busy0", busy_cnt, 0);

        fu_ready = 0;
        issue(0, 0, 6, 5, 0, 10);
        issue(0, 1, 0, 2, 0, 11);
        check("age_young_sel", fu_dest, 11);
        sb.push_back(op(0, 10, 100, 5));
        sb.push_back(op(0, 11, 1, 2));
        cdb(6, 100);
        check("age_old_sel", fu_dest, 10);
        fu_ready = 1;
        step(); step();
        check("age_busy0", busy_cnt, 0);

        sb.push_back(op(0, 14, 1, 1));
        issue(0, 1, 0, 1, 0, 14);
        sb.push_back(op(1, 15, 2, 3));
        issue(1, 2, 0, 3, 0, 15);
        check("simul_busy", busy_cnt, 1);
        check("simul_next", fu_dest, 15);
        step();
        check("simul_busy0", busy_cnt, 0);

        issue(0, 0, 12, 1, 0, 12);
        issue(0, 0, 13, 0, 12, 13);
        check("rst_mid_busy", busy_cnt, 2);
        cdb(9, 55);
        check("nomatch_valid", fu_valid, 0);
        check("nomatch_busy", busy_cnt, 2);
        rst = 1;
        step();
        rst = 0;
        check("rst_mid_busy0", busy_cnt, 0);
        check("rst_mid_ready", issue_ready, 1);
        cdb(12, 77);
        check("rst_mid_cdb", fu_valid, 0);
        step();
        check("rst_mid_cdb2", {fu_valid, busy_cnt}, 0);

`ifdef ADD_RS_FLUSH_EN
        issue(0, 0, 12, 1, 0, 12);
        issue(0, 0, 13, 0, 12, 13);
        check("flush_pre_busy", busy_cnt, 2);
        flush = 1;
        step();
        flush = 0;
        check("flush_busy0", busy_cnt, 0);
        check("flush_ready", issue_ready, 1);
        cdb(12, 77);
        check("flush_cdb", fu_valid, 0);
        step();
        check("flush_cdb2", {fu_valid, busy_cnt}, 0);
`endif

        step();
        check("sb_empty", 96'(sb.size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
